// File: rtl/uart_pkg.sv
// uart_pkg: shared UART word size, default FIFO depth and receive-ack state type
package uart_pkg;
    localparam int UART_WORD_SIZE = 8;
    localparam int UART_FIFO_DEPTH = 16;
    typedef enum logic {ACK_IDLE, ACK_ACK} ack_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through buffer behind a UART receiver with a level/ack handshake
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WORD_SIZE = UART_WORD_SIZE,
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [WORD_SIZE-1:0]   rx_data,
    output logic                   rx_ack,
    input  logic                   rd_en,
    output logic [WORD_SIZE-1:0]   rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    ack_state_e state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic overflow_q, overflow_d;
    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic accept, do_wr, do_rd;
    always_comb begin
        accept = rx_valid && (state_q == ACK_IDLE);
        do_rd = rd_en && !empty;
        // a full buffer still takes the word when the same edge frees a slot
        do_wr = accept && (!full || rd_en);
        state_d = accept ? ACK_ACK : ACK_IDLE;
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = (accept && full && !rd_en) || (overflow_q && !clr_overflow);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACK_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
    end
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = count == '0;
    assign full = count == FULL_CNT;
    assign rx_ack = state_q == ACK_ACK;
    assign overflow = overflow_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the receive FIFO handshake, ordering, overflow and reset
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_ack;
    logic rd_en = 1'b0;
    logic [7:0] rd_data;
    logic empty, full, overflow;
    logic [4:0] count;
    logic clr_overflow = 1'b0;
    int passed = 0;
    int total = 0;
    int ack_pulses = 0;

    uart_rx_fifo dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rx_ack) ack_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // receiver holds rx_valid through the ack cycle, as a real receiver would
    task automatic push(input logic [7:0] d, input logic rd, input logic clr);
        rx_valid = 1'b1;
        rx_data = d;
        rd_en = rd;
        clr_overflow = clr;
        @(negedge clk);
        rd_en = 1'b0;
        clr_overflow = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        chk(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ack", 32'(rx_ack), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        ack_pulses = 0;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        @(negedge clk);
        chk("single_ack", 32'(rx_ack), 1);
        chk("single_count", 32'(count), 1);
        chk("single_data", 32'(rd_data), 32'h A5);
        chk("single_empty", 32'(empty), 0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("single_ack_low", 32'(rx_ack), 0);
        chk("single_no_dup", 32'(count), 1);
        @(negedge clk);
        chk("single_pulses", 32'(ack_pulses), 1);
        pop("single_pop", 8'hA5);
        chk("single_drained", 32'(empty), 1);

        for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);

        ack_pulses = 0;
        push(8'hFF, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(ack_pulses), 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        push(8'hFE, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        push(8'h55, 1'b1, 1'b0);
        chk("simul_count", 32'(count), 16);
        chk("simul_ovf", 32'(overflow), 0);
        for (int i = 1; i < 16; i++) pop($sformatf("order_%0d", i), 8'(i));
        pop("simul_last", 8'h55);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        rd_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        chk("underflow_count", 32'(count), 0);
        chk("underflow_empty", 32'(empty), 1);
        push(8'h3C, 1'b0, 1'b0);
        chk("after_uf_count", 32'(count), 1);
        pop("after_uf_data", 8'h3C);

        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b0, 1'b0);
        rx_valid = 1'b1;
        rx_data = 8'h99;
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 5);
        chk("pre_rst_ack", 32'(rx_ack), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_count", 32'(count), 0);
        chk("arst_ack", 32'(rx_ack), 0);
        chk("arst_full", 32'(full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reaccept_count", 32'(count), 1);
        chk("reaccept_data", 32'(rd_data), 32'h99);
        chk("reaccept_ack", 32'(rx_ack), 1);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("reaccept_once", 32'(count), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of buffered words; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx_valid  input  1  receiver data-available flag; level, held high until acknowledged.
REQ-006 SHALL have port rx_data  input  WORD_SIZE  received word; stable while rx_valid high.
REQ-007 SHALL have port rx_ack  output  1  one-cycle acknowledge to the receiver, which clears its rx_valid.
REQ-008 SHALL have port rd_en  input  1  consumer pops the head word.
REQ-009 SHALL have port rd_data  output  WORD_SIZE  head word, first-word-fall-through.
REQ-010 SHALL have port empty  output  1  no words stored.
REQ-011 SHALL have port full  output  1  DEPTH words stored.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  words stored, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: a word was dropped because the buffer was full.
REQ-014 SHALL have port clr_overflow  input  1  clears overflow.

Function
REQ-015 SHALL accept a word on a rising edge where rx_valid=1 and rx_ack=0.
REQ-016 SHALL register rx_ack=1 for exactly the cycle following each accept, then return it to 0.
REQ-017 SHALL ignore rx_valid while rx_ack=1, so a level held high for one extra cycle is never written twice.
REQ-018 SHALL write rx_data at the write pointer on accept when not full, or when full and rd_en=1 in the same cycle.
REQ-019 SHALL drop the word on accept when full and rd_en=0, set overflow=1, and still pulse rx_ack.
REQ-020 SHALL drive rd_data from the head entry combinationally; it is valid whenever empty=0.
REQ-021 SHALL make a written word visible on rd_data the cycle after its accept edge (1-cycle latency).
REQ-022 SHALL advance the read pointer on rd_en=1 with empty=0, and ignore rd_en when empty=1 (no underflow, count stays 0).
REQ-023 SHALL, on simultaneous write and pop, leave count unchanged and move both pointers.
REQ-024 SHALL wrap pointers modulo DEPTH, using one extra pointer bit to distinguish full from empty.
REQ-025 SHALL derive empty, full and count from the pointers: empty = (count==0), full = (count==DEPTH).
REQ-026 SHALL clear overflow on clr_overflow=1; if a drop occurs in the same cycle, set wins.
REQ-027 SHALL have no state machine beyond the ack flag: ack states IDLE and ACK, with IDLE->ACK on accept and ACK->IDLE unconditionally.

Reset
REQ-028 SHALL on rst_n=0 asynchronously clear both pointers, rx_ack and overflow, giving empty=1, full=0, count=0.
REQ-029 SHALL not reset storage contents; rd_data is don't-care while empty=1.
REQ-030 SHALL, on reset mid-operation, discard all stored words and any pending ack; a receiver still holding rx_valid is re-accepted after reset release.

Structure
REQ-031 SHALL take WORD_SIZE and the default DEPTH from shared package uart_pkg, which the receiver and transmitter also use.
REQ-032 SHALL implement storage as a register array inside the module; no sub-module.

Verification
REQ-033 Single word: rx_valid=1, rx_data=8'hA5 held 2 cycles -> exactly one rx_ack pulse, count=1, rd_data=8'hA5 next cycle, empty=0.
REQ-034 Fill: 16 words 8'h00..8'h0F -> full=1, count=16; 16 pops return 8'h00..8'h0F in order, then empty=1.
REQ-035 Overflow: full buffer, write 8'hFF with rd_en=0 -> rx_ack pulses, word dropped, overflow=1, count=16; clr_overflow -> overflow=0.
REQ-036 Full with simultaneous pop: full, write 8'h55 with rd_en=1 -> count stays 16, overflow=0, 8'h55 is the last word popped.
REQ-037 Empty pop: rd_en=1 while empty -> count=0, pointers unchanged, a following write of 8'h3C reads back as 8'h3C.
REQ-038 Async reset: assert rst_n=0 between edges with count=5 -> empty=1, count=0, rx_ack=0 immediately, without waiting for a clock edge.
